// File: rtl/ysyx_23060096_pkg.sv
// ysyx_23060096_pkg: shared IFU state encoding, reset PC and NOP constant
package ysyx_23060096_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_FAULT} ifu_state_t;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/ysyx_23060096_perf_cnt.sv
// ysyx_23060096_perf_cnt: 64-bit enable-increment event counter
module ysyx_23060096_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [63:0] cnt
);
  // count one per enabled cycle, cleared by async reset
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (en) cnt <= cnt + 64'd1;
endmodule

// File: rtl/ysyx_23060096_ifu.sv
// ysyx_23060096_ifu: single-outstanding instruction fetch unit with redirect, stale-drop and misalignment fault; YSYX_23060096_IFU_PERF_EN adds perf counters
module ysyx_23060096_ifu
  import ysyx_23060096_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
`ifdef YSYX_23060096_IFU_PERF_EN
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt,
`endif
  output logic            id_fault
);
  ifu_state_t      state;
  logic [XLEN-1:0] pc;
  logic            drop;
  logic            mis;
  assign mis = redirect_pc[1:0] != 2'b00;
  assign imem_req_valid = (state == S_REQ) & ~redirect_valid;
  assign imem_req_addr = pc;
  // fetch FSM; a redirect overrides every state, a stale in-flight word is dropped via drop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      drop <= 1'b0;
      id_valid <= 1'b0;
      id_fault <= 1'b0;
      id_inst <= '0;
      id_pc <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      drop <= (state == S_WAIT && !mis) ? ~imem_rsp_valid : drop;
      id_valid <= mis;
      id_fault <= mis;
      state <= mis ? S_FAULT : S_REQ;
      if (mis) begin
        id_inst <= NOP_INST;
        id_pc <= redirect_pc;
      end
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: if (imem_req_ready) state <= S_WAIT;
        S_WAIT:
          if (imem_rsp_valid) begin
            drop <= 1'b0;
            state <= drop ? S_REQ : S_OUT;
            if (!drop) begin
              id_inst <= imem_rsp_data;
              id_pc <= pc;
              id_valid <= 1'b1;
            end
          end
        S_OUT:
          if (id_ready) begin
            pc <= pc + XLEN'(4);
            id_valid <= 1'b0;
            state <= S_REQ;
          end
        S_FAULT: if (id_ready) id_valid <= 1'b0;
        default: state <= S_IDLE;
      endcase
    end
`ifdef YSYX_23060096_IFU_PERF_EN
  ysyx_23060096_perf_cnt u_fetch_cnt (
    .clk(clk),
    .rst(rst),
    .en (state == S_OUT && id_ready && !redirect_valid),
    .cnt(perf_fetch_cnt)
  );
  ysyx_23060096_perf_cnt u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .en (state == S_REQ || state == S_WAIT),
    .cnt(perf_stall_cnt)
  );
`endif
endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// tb_ysyx_23060096_ifu: directed and random checks of the IFU against a PC/scoreboard model
module tb_ysyx_23060096_ifu;
  localparam logic [31:0] RPC = 32'h8000_0000;
  logic        clk = 0;
  logic        rst = 1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 0;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        id_valid;
  logic        id_ready = 0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_fault;
`ifdef YSYX_23060096_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt, perf_stall_cnt;
`endif
  int total = 0, bad = 0;
  logic [31:0] exp_pc = RPC;
  bit in_fault = 0, fault_taken = 0;
  int hs = 0, total_hs = 0;
  bit mem_busy = 0;
  int mem_lat = 0, lat_min = 1, lat_max = 1;
  logic [31:0] mem_addr = 0;
  bit rdy_rand = 0;

  ysyx_23060096_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
`ifdef YSYX_23060096_IFU_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .id_fault(id_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == RPC) ? 32'h0050_0093 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0003);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare against the model mid-cycle, then advance model and memory bookkeeping
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = RPC; in_fault = 0; fault_taken = 0; hs = 0; mem_busy = 0;
    end else begin
      if (in_fault) begin
        chk("fault_valid", id_valid, !fault_taken);
        chk("fault_flag", id_fault, 1);
        chk("fault_noreq", imem_req_valid, 0);
        if (id_valid) begin
          chk("fault_inst", id_inst, 32'h13);
          chk("fault_pc", id_pc, exp_pc);
        end
      end else begin
        chk("no_fault", id_fault, 0);
        if (id_valid) begin
          chk("id_pc", id_pc, exp_pc);
          chk("id_inst", id_inst, mem_word(exp_pc));
        end
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
      end
      if (redirect_valid) chk("req_suppress", imem_req_valid, 0);
      if (redirect_valid) begin
        exp_pc = redirect_pc; in_fault = |redirect_pc[1:0]; fault_taken = 0;
      end else if (id_valid && id_ready) begin
        if (in_fault) fault_taken = 1;
        else begin exp_pc += 4; hs++; total_hs++; end
      end
      if (imem_rsp_valid) mem_busy = 0;
      if (imem_req_valid && imem_req_ready) begin
        mem_busy = 1; mem_addr = imem_req_addr; mem_lat = $urandom_range(lat_max, lat_min);
      end
    end
  end

  // in-order single-outstanding memory responding mem_word(addr) after mem_lat cycles
  initial forever begin
    @(posedge clk); #1;
    if (mem_busy) begin
      mem_lat--;
      imem_rsp_valid = (mem_lat == 0);
      imem_rsp_data = (mem_lat == 0) ? mem_word(mem_addr) : $urandom;
    end else imem_rsp_valid = 0;
    imem_req_ready = !mem_busy && (!rdy_rand || $urandom_range(2, 0) != 0);
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string name);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = id_valid;
    end
    if (!got) chk(name, 0, 1);
  endtask

  task automatic pulse_ready;
    step; id_ready = 1;
    step; id_ready = 0;
  endtask

  initial begin
    repeat (2) step;
    @(negedge clk);
    chk("rst_valid", id_valid, 0);
    chk("rst_fault", id_fault, 0);
    chk("rst_inst", id_inst, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_req", imem_req_valid, 0);
    chk("rst_addr", imem_req_addr, RPC);
    step; rst = 0;
    @(negedge clk);
    chk("idle_noreq", imem_req_valid, 0);
    @(negedge clk);
    chk("first_req", imem_req_valid, 1);
    chk("first_addr", imem_req_addr, RPC);
    @(negedge clk);
    @(negedge clk);
    chk("first_valid", id_valid, 1);
    chk("first_inst", id_inst, 32'h0050_0093);
    chk("first_pc", id_pc, RPC);
    for (int i = 0; i < 5; i++) begin
      step; @(negedge clk);
      chk("hold_valid", id_valid, 1);
      chk("hold_inst", id_inst, 32'h0050_0093);
      chk("hold_pc", id_pc, RPC);
      chk("hold_noreq", imem_req_valid, 0);
    end
    step; id_ready = 1; lat_min = 3; lat_max = 3;
    step; id_ready = 0;
    @(negedge clk);
    chk("next_req", imem_req_valid, 1);
    chk("next_addr", imem_req_addr, 32'h8000_0004);
    step; redirect_valid = 1; redirect_pc = 32'h8000_1000;
    step; redirect_valid = 0; lat_min = 1; lat_max = 1;
    @(negedge clk);
    chk("redir_addr", imem_req_addr, 32'h8000_1000);
    wait_valid("redir_timeout");
    chk("redir_pc", id_pc, 32'h8000_1000);
    chk("redir_inst", id_inst, mem_word(32'h8000_1000));
    step; id_ready = 1; redirect_valid = 1; redirect_pc = 32'h8000_2000;
    step; id_ready = 0; redirect_valid = 0;
    @(negedge clk);
    chk("squash_valid", id_valid, 0);
    chk("squash_req", imem_req_valid, 1);
    chk("squash_addr", imem_req_addr, 32'h8000_2000);
    wait_valid("squash_timeout");
    chk("squash_pc", id_pc, 32'h8000_2000);
    step; redirect_valid = 1; redirect_pc = 32'h8000_0002;
    step; redirect_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mis_fault", id_fault, 1);
      chk("mis_valid", id_valid, 1);
      chk("mis_inst", id_inst, 32'h13);
      chk("mis_pc", id_pc, 32'h8000_0002);
      chk("mis_noreq", imem_req_valid, 0);
      step;
    end
    id_ready = 1;
    step; id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mis_done_valid", id_valid, 0);
      chk("mis_done_noreq", imem_req_valid, 0);
      step;
    end
    redirect_valid = 1; redirect_pc = 32'h8000_0100;
    step; redirect_valid = 0;
    wait_valid("exit_timeout");
    chk("exit_pc", id_pc, 32'h8000_0100);
    lat_min = 3; lat_max = 3;
    pulse_ready;
    begin
      bit acc = 0;
      for (int i = 0; i < 20 && !acc; i++) begin
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready;
      end
      if (!acc) chk("acc_timeout", 0, 1);
    end
    step; rst = 1; #1;
    chk("arst_valid", id_valid, 0);
    chk("arst_inst", id_inst, 0);
    chk("arst_pc", id_pc, 0);
    chk("arst_req", imem_req_valid, 0);
    chk("arst_addr", imem_req_addr, RPC);
`ifdef YSYX_23060096_IFU_PERF_EN
    chk("arst_fetch", perf_fetch_cnt, 0);
    chk("arst_stall", perf_stall_cnt, 0);
`endif
    step; rst = 0; lat_min = 1; lat_max = 3; rdy_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      step;
      id_ready = $urandom_range(3, 0) != 0;
      redirect_valid = $urandom_range(19, 0) == 0;
      redirect_pc = RPC + ($urandom_range(255, 0) << 2) + (($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0);
      rst = $urandom_range(1499, 0) == 0;
    end
    step; id_ready = 0; redirect_valid = 0; rst = 0;
    repeat (2) step;
    @(negedge clk);
    chk("progress", total_hs > 200, 1);
`ifdef YSYX_23060096_IFU_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, hs);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
